// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field layout and exponent bias.
package fpu_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

    typedef struct packed {
        logic                 s;
        logic [FP_EXP_W-1:0]  e;
        logic [FP_FRAC_W-1:0] f;
    } fp32_t;

    // Positive zero, the only zero the integer converters ever emit.
    function automatic fp32_t fp_pos_zero();
        fp32_t z;
        z = '0;
        return z;
    endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; reports 32 for an all-zero word.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  count
);

    logic found;

    always_comb begin
        count = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && a[i]) begin
                count = 6'(31 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer to single-precision converter (abs, normalize, round/pack)
// with a single stall-everything advance enable driven by the output handshake.
module itof_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic        is_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    logic        en;
    logic        v1, v2, v3;

    logic        s_p1;
    logic [31:0] a_p1;

    logic        s_p2;
    logic        zero_p2;
    logic [31:0] n_p2;
    logic [8:0]  e_p2;

    logic [31:0] y_p3;

    logic        s_in;
    logic [31:0] a_in;
    logic [5:0]  lz;

    function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic neg);
        return neg ? (~v + 32'sd1) : v;
    endfunction

    // Round to nearest even on the 24-bit mantissa; a carry out renormalizes to 1.0.
    function automatic fp32_t round_pack(input logic s, input logic [8:0] e, input logic [31:0] n);
        logic [23:0] m;
        logic        up;
        logic [24:0] m_r;
        logic [8:0]  e_r;
        fp32_t       r;
        m   = n[31:8];
        up  = n[7] & ((|n[6:0]) | m[0]);
        m_r = {1'b0, m} + {24'd0, up};
        e_r = e;
        if (m_r[24]) begin
            r.f = '0;
            e_r = e + 9'd1;
        end else begin
            r.f = m_r[FP_FRAC_W-1:0];
        end
        r.s = s;
        r.e = e_r[FP_EXP_W-1:0];
        return r;
    endfunction

    assign en        = ~v3 | out_ready;
    assign in_ready  = en;
    assign out_valid = v3;
    assign y         = y_p3;

    assign s_in = ~is_unsigned & x[31];
    assign a_in = magnitude(x, s_in);

    lzc32 u_lzc (
        .a     (a_p1),
        .count (lz)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s_p1    <= 1'b0;
            a_p1    <= '0;
            s_p2    <= 1'b0;
            zero_p2 <= 1'b0;
            n_p2    <= '0;
            e_p2    <= '0;
            y_p3    <= '0;
        end else if (en) begin
            // stage 1: sign and magnitude
            v1   <= in_valid;
            s_p1 <= s_in;
            a_p1 <= a_in;
            // stage 2: normalize so bit 31 carries the leading one
            v2      <= v1;
            s_p2    <= s_p1;
            zero_p2 <= (a_p1 == 32'd0);
            n_p2    <= a_p1 << lz[4:0];
            e_p2    <= 9'(FP_BIAS + 31) - {3'b000, lz};
            // stage 3: round and pack; bubbles and zero both leave +0.0 on y
            v3   <= v2;
            y_p3 <= (v2 && !zero_p2) ? round_pack(s_p2, e_p2, n_p2) : fp_pos_zero();
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe against an arithmetic rounding model.
module tb_itof_pipe;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    itof_pipe dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .is_unsigned (is_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact value rounded to 24 significant bits by comparing the discarded
    // remainder against half an ulp.
    function automatic logic [31:0] ref_itof(input logic [31:0] xv, input logic uv);
        longint          sv;
        longint unsigned mag, q, rem, half;
        int              k, sh;
        logic            sg;
        if (uv) begin
            sg  = 1'b0;
            mag = {32'd0, xv};
        end else begin
            sv  = longint'($signed(xv));
            sg  = (sv < 0);
            mag = sg ? 64'(-sv) : 64'(sv);
        end
        if (mag == 0) return 32'h0;
        k = 0;
        for (int i = 0; i < 40; i++) if (mag >= (64'd1 << i)) k = i;
        if (k <= 23) begin
            q = mag << (23 - k);
        end else begin
            sh   = k - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                k = k + 1;
            end
        end
        return {sg, 8'(k + 127), q[22:0]};
    endfunction

    // One clock: drive at the falling edge, sample just after, then cross the rising edge.
    task automatic step(input logic iv, input logic [31:0] xv, input logic uv, input logic orv,
                        output logic acc_in, output logic acc_out, output logic [31:0] yv,
                        output logic ir, output logic ov);
        in_valid    = iv;
        x           = xv;
        is_unsigned = uv;
        out_ready   = orv;
        #1;
        ir      = in_ready;
        ov      = out_valid;
        acc_in  = iv & in_ready;
        acc_out = out_valid & orv;
        yv      = y;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b1;
        in_valid = 1'b0; x = '0; is_unsigned = 1'b0; out_ready = 1'b1;
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", y); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] xs [11];
        logic        us [11];
        logic [31:0] ex [11];
        logic        ai, ao, ir, ov;
        logic [31:0] yv;
        int          sent, got, first;
        xs = '{32'h1, 32'hFFFFFFFF, 32'h0, 32'h01000001, 32'h01000003, 32'h01000005,
               32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
        us = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ex = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h4B800000, 32'h4B800002, 32'h4B800002,
               32'h4F000000, 32'hCF000000, 32'h4F800000, 32'h4F000000, 32'h00000000};
        sent = 0; got = 0; first = -1;
        for (int c = 0; c < 40 && got < 11; c++) begin
            step(sent < 11, (sent < 11) ? xs[sent] : 32'h0, (sent < 11) ? us[sent] : 1'b0, 1'b1,
                 ai, ao, yv, ir, ov);
            if (ai) sent++;
            if (ao) begin
                if (first < 0) first = c;
                checks++;
                if (yv !== ex[got]) begin
                    errors++;
                    $display("FAIL basic[%0d] x=%h u=%0b got %h want %h", got, xs[got], us[got], yv, ex[got]);
                end
                got++;
            end
        end
        checks++;
        if (first != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", first); end
        checks++;
        if (got != 11) begin errors++; $display("FAIL basic_count got %0d want 11", got); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q [$];
        logic        ai, ao, ir, ov, orv, uv, prev_stall;
        logic [31:0] yv, xv, prev_y, e;
        int          sent, got;
        sent = 0; got = 0; prev_stall = 1'b0; prev_y = '0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            xv  = $urandom;
            uv  = 1'($urandom % 2);
            orv = 1'($urandom % 2);
            step(sent < 8, xv, uv, orv, ai, ao, yv, ir, ov);
            checks++;
            if (ir !== (~ov | orv)) begin
                errors++;
                $display("FAIL bp_in_ready got %0b want %0b", ir, ~ov | orv);
            end
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || yv !== prev_y) begin
                    errors++;
                    $display("FAIL bp_stall_hold got v=%0b y=%h want v=1 y=%h", ov, yv, prev_y);
                end
            end
            prev_stall = ov & ~orv;
            prev_y     = yv;
            if (ai) begin q.push_back(ref_itof(xv, uv)); sent++; end
            if (ao) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_output got %h want none", yv);
                end else begin
                    e = q.pop_front();
                    if (yv !== e) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", got, yv, e); end
                end
                got++;
            end
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL bp_count got %0d want 8", got); end
    endtask

    task automatic test_reset_mid;
        logic        ai, ao, ir, ov;
        logic [31:0] yv;
        int          stale, got, at;
        for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b1, ai, ao, yv, ir, ov);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 32'h0) begin
            errors++;
            $display("FAIL midreset_clear got v=%0b y=%h want v=0 y=00000000", out_valid, y);
        end
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, ai, ao, yv, ir, ov);
            if (ov) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL midreset_stale got %0d outputs want 0", stale); end
        got = 0; at = -1;
        for (int c = 0; c < 10 && got == 0; c++) begin
            step(c == 0, 32'd2, 1'b0, 1'b1, ai, ao, yv, ir, ov);
            if (ao) begin
                got = 1; at = c;
                checks++;
                if (yv !== 32'h40000000) begin errors++; $display("FAIL midreset_two got %h want 40000000", yv); end
            end
        end
        checks++;
        if (at != 3) begin errors++; $display("FAIL midreset_latency got %0d want 3", at); end
    endtask

    task automatic test_random;
        logic [31:0] q [$];
        logic        ai, ao, ir, ov, orv, uv;
        logic [31:0] yv, xv, e;
        int          sent, got, sel;
        sent = 0; got = 0;
        for (int c = 0; c < 40000 && got < 10000; c++) begin
            sel = int'($urandom % 8);
            case (sel)
                0:       xv = 32'h80000000 ^ ($urandom % 4);
                1:       xv = $urandom % 512;
                2:       xv = 32'hFFFFFFFF - ($urandom % 512);
                3:       xv = (32'h1 << ($urandom % 32)) | ($urandom % 512);
                default: xv = $urandom;
            endcase
            uv  = 1'($urandom % 2);
            orv = ($urandom % 4) != 0;
            step(sent < 10000, xv, uv, orv, ai, ao, yv, ir, ov);
            if (ai) begin q.push_back(ref_itof(xv, uv)); sent++; end
            if (ao) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_output got %h want none", yv);
                end else begin
                    e = q.pop_front();
                    if (yv !== e) begin errors++; $display("FAIL rand[%0d] got %h want %h", got, yv, e); end
                end
                got++;
            end
        end
        checks++;
        if (got != 10000) begin errors++; $display("FAIL rand_count got %0d want 10000", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
